// File: rtl/irq_input_conditioner_pkg.sv
// irq_pkg: shared address map and default sizes for the IRQ input conditioner
package irq_pkg;
  localparam int IRQ_N_IRQ = 4;
  localparam int IRQ_CNT_W = 8;
  localparam logic [31:0] IRQ_ADDR_POLARITY = 32'd4;
  localparam logic [31:0] IRQ_ADDR_MODE     = 32'd5;
  localparam logic [31:0] IRQ_ADDR_DEBOUNCE = 32'd6;
endpackage

// File: rtl/irq_input_conditioner_if.sv
// irq_input_conditioner_if: APB bus carrying the conditioner's configuration accesses
interface irq_input_conditioner_if;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic pready, pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/irq_line_filter.sv
// irq_line_filter: one request line's synchroniser, polarity fix, debounce and level/edge output
module irq_line_filter #(
  parameter int CNT_W = 8
) (
  input  logic             pclk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             raw_i,
  input  logic             polarity_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] debounce_i,
  output logic             trigger_o
);
  logic sync1, sync2, cond, stable, stable_nxt, settle;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // a differing cond that has already lasted debounce_i extra cycles becomes the new stable value
  assign settle = (cond != stable) && (cnt >= debounce_i);
  always_comb begin
    stable_nxt = settle ? cond : stable;
    cnt_nxt = (cond == stable || settle) ? '0 : cnt + CNT_W'(1);
  end
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cond <= 1'b0;
      stable <= 1'b0;
      cnt <= '0;
      trigger_o <= 1'b0;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
      cond <= sync2 ^ polarity_i;
      if (enable_i) begin
        stable <= stable_nxt;
        cnt <= cnt_nxt;
      end
      trigger_o <= enable_i & (mode_i ? stable_nxt & ~stable : stable_nxt);
    end
  end
endmodule

// File: rtl/irq_input_conditioner.sv
// irq_input_conditioner: APB configuration registers driving one irq_line_filter per request line
module irq_input_conditioner import irq_pkg::*; #(
  parameter int N_IRQ = IRQ_N_IRQ,
  parameter int CNT_W = IRQ_CNT_W
) (
  input  logic                     pclk_i,
  input  logic                     rst_i,
  irq_input_conditioner_if.slave   apb,
  input  logic                     enable_i,
  input  logic [N_IRQ-1:0]         irq_raw_i,
  output logic [N_IRQ-1:0]         irq_trigger_o
);
  logic [N_IRQ-1:0] polarity, mode;
  logic [CNT_W-1:0] debounce;
  logic wr, rd;
  logic [31:0] rdata;
  assign wr = apb.psel & apb.penable & apb.pwrite;
  assign rd = apb.psel & ~apb.penable & ~apb.pwrite;
  assign apb.pready = 1'b1;
  assign apb.pslverr = 1'b0;
  always_comb rdata = apb.paddr == IRQ_ADDR_POLARITY ? 32'(polarity) :
                      apb.paddr == IRQ_ADDR_MODE     ? 32'(mode) :
                      apb.paddr == IRQ_ADDR_DEBOUNCE ? 32'(debounce) : '0;
  // read data is captured in the setup phase so it is steady across the access phase
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      polarity <= '0;
      mode <= '0;
      debounce <= '0;
      apb.prdata <= '0;
    end else begin
      if (wr && apb.paddr == IRQ_ADDR_POLARITY) polarity <= apb.pwdata[N_IRQ-1:0];
      if (wr && apb.paddr == IRQ_ADDR_MODE) mode <= apb.pwdata[N_IRQ-1:0];
      if (wr && apb.paddr == IRQ_ADDR_DEBOUNCE) debounce <= apb.pwdata[CNT_W-1:0];
      if (rd) apb.prdata <= rdata;
    end
  end
  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    irq_line_filter #(.CNT_W(CNT_W)) u_line (
      .pclk_i     (pclk_i),
      .rst_i      (rst_i),
      .enable_i   (enable_i),
      .raw_i      (irq_raw_i[i]),
      .polarity_i (polarity[i]),
      .mode_i     (mode[i]),
      .debounce_i (debounce),
      .trigger_o  (irq_trigger_o[i])
    );
  end
endmodule
